// File: rtl/huffman_pkg.sv
// Shared state encoding, tree-node type and width helpers for the Huffman code generator.
// Node fields are sized for the largest legal instance; narrower instances keep the upper bits at zero.
package huffman_pkg;

  localparam int MAXN = 16;
  localparam int MAXW = 32;

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    SORT,
    MERGE,
    DONE
  } state_t;

  typedef struct packed {
    logic [MAXN-1:0] mask;
    logic [MAXW-1:0] weight;
  } node_t;

  function automatic int sw_f(input int nsym);
    return $clog2(nsym + 1);
  endfunction

  function automatic int ww_f(input int cw, input int nsym);
    return cw + $clog2(nsym);
  endfunction

  // All-ones weight of the live width: strictly above any reachable sum, so empty slots sink.
  function automatic logic [MAXW-1:0] sentinel_w(input int ww);
    return MAXW'((64'd1 << ww) - 64'd1);
  endfunction

endpackage

// File: rtl/huffman_oet_pass.sv
// One combinational odd-even transposition row; zero latency, no flow control.
// Exchanges on strict greater-than; with tie_en_i, equal weights put the higher symbol index first.
module huffman_oet_pass
  import huffman_pkg::*;
#(
  parameter int NSYM = 6
) (
  input  logic             parity_i,
  input  logic             tie_en_i,
  input  node_t [NSYM-1:0] node_i,
  output node_t [NSYM-1:0] node_o
);

  always_comb begin
    node_o = node_i;
    for (int i = 0; i < NSYM - 1; i++) begin
      if ((i % 2) == int'(parity_i)) begin
        if ((node_i[i].weight > node_i[i+1].weight) ||
            (tie_en_i && (node_i[i].weight == node_i[i+1].weight) &&
             (node_i[i].mask < node_i[i+1].mask))) begin
          node_o[i]   = node_i[i+1];
          node_o[i+1] = node_i[i];
        end
      end
    end
  end

endmodule

// File: rtl/huffman_gen.sv
// Framed symbol counter plus Huffman tree builder; codes valid (NSYM-1)(NSYM+1)+1 cycles after the last beat.
// in_ready drops for the whole SORT/MERGE build; beats are accepted again once codes are presented.
module huffman_gen
  import huffman_pkg::*;
#(
  parameter int NSYM = 6,
  parameter int DW   = 8,
  parameter int CW   = 8,
  parameter int LW   = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DW-1:0]     in_data,
  input  logic              in_last,
  output logic              cnt_valid,
  output logic [NSYM*CW-1:0] cnt,
  output logic              code_valid,
  output logic [NSYM*LW-1:0] hc,
  output logic [NSYM*LW-1:0] hm
);

  localparam int SW = sw_f(NSYM);
  localparam int WW = ww_f(CW, NSYM);
  localparam int KW = $clog2(NSYM + 1);
  localparam logic [MAXW-1:0] SENT_W  = sentinel_w(WW);
  localparam logic [CW-1:0]   CNT_MAX = '1;

  state_t              state_q, state_d;
  logic [NSYM*CW-1:0]  cnt_q, cnt_d;
  logic [NSYM*LW-1:0]  hc_q, hc_d, hm_q, hm_d;
  node_t [NSYM-1:0]    node_q, node_d, node_sorted;
  logic [KW-1:0]       step_q, step_d, merge_q, merge_d;
  logic                first_q, first_d;
  logic                cnt_valid_q, cnt_valid_d;
  logic                code_valid_q, code_valid_d;
  logic                acc;
  logic [SW-1:0]       sym;
  logic [LW-1:0]       hm_new;

  assign in_ready   = (state_q != SORT) && (state_q != MERGE);
  assign acc        = in_valid && in_ready;
  assign sym        = in_data[SW-1:0];
  assign cnt        = cnt_q;
  assign hc         = hc_q;
  assign hm         = hm_q;
  assign cnt_valid  = cnt_valid_q;
  assign code_valid = code_valid_q;

  if (DW > SW) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^in_data[DW-1:SW];
  end

  huffman_oet_pass #(.NSYM(NSYM)) u_pass (
    .parity_i (step_q[0]),
    .tie_en_i (first_q),
    .node_i   (node_q),
    .node_o   (node_sorted)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    hc_d         = hc_q;
    hm_d         = hm_q;
    node_d       = node_q;
    step_d       = step_q;
    merge_d      = merge_q;
    first_d      = first_q;
    cnt_valid_d  = 1'b0;
    code_valid_d = code_valid_q;
    hm_new       = '0;
    case (state_q)
      IDLE, COUNT, DONE: begin
        if (acc) begin
          if (state_q != COUNT) begin
            cnt_d        = '0;
            hc_d         = '0;
            hm_d         = '0;
            code_valid_d = 1'b0;
          end
          for (int i = 0; i < NSYM; i++) begin
            if ((sym == SW'(i + 1)) && (cnt_d[i*CW +: CW] != CNT_MAX))
              cnt_d[i*CW +: CW] = cnt_d[i*CW +: CW] + CW'(1);
          end
          state_d = COUNT;
          if (in_last) begin
            state_d     = SORT;
            cnt_valid_d = 1'b1;
            step_d      = '0;
            merge_d     = '0;
            first_d     = 1'b1;
            for (int i = 0; i < NSYM; i++)
              node_d[i] = '{mask: MAXN'(1) << i, weight: MAXW'(cnt_d[i*CW +: CW])};
          end
        end
      end
      SORT: begin
        node_d = node_sorted;
        step_d = step_q + KW'(1);
        if (step_q == KW'(NSYM - 1)) state_d = MERGE;
      end
      MERGE: begin
        // Node0 members take a 1, node1 members a 0, at their current code length.
        for (int i = 0; i < NSYM; i++) begin
          if (node_q[0].mask[i] || node_q[1].mask[i]) begin
            hm_new = (hm_q[i*LW +: LW] << 1) | LW'(1);
            hm_d[i*LW +: LW] = hm_new;
            if (node_q[0].mask[i])
              hc_d[i*LW +: LW] = hc_q[i*LW +: LW] | (hm_new & ~hm_q[i*LW +: LW]);
          end
        end
        node_d[0] = '{mask:   node_q[0].mask | node_q[1].mask,
                      weight: node_q[0].weight + node_q[1].weight};
        for (int i = 1; i < NSYM - 1; i++) node_d[i] = node_q[i+1];
        node_d[NSYM-1] = '{mask: '0, weight: SENT_W};
        first_d = 1'b0;
        step_d  = '0;
        merge_d = merge_q + KW'(1);
        if (merge_q == KW'(NSYM - 2)) begin
          state_d      = DONE;
          code_valid_d = 1'b1;
        end else begin
          state_d = SORT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      hc_q         <= '0;
      hm_q         <= '0;
      node_q       <= '0;
      step_q       <= '0;
      merge_q      <= '0;
      first_q      <= 1'b0;
      cnt_valid_q  <= 1'b0;
      code_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      hc_q         <= hc_d;
      hm_q         <= hm_d;
      node_q       <= node_d;
      step_q       <= step_d;
      merge_q      <= merge_d;
      first_q      <= first_d;
      cnt_valid_q  <= cnt_valid_d;
      code_valid_q <= code_valid_d;
    end
  end

endmodule

// File: tb/tb_huffman_gen.sv
// Directed bench for huffman_gen: a 6-symbol instance and a 4-symbol, 3-bit-code instance.
module tb_huffman_gen;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic        a_in_valid, a_in_ready, a_in_last, a_cnt_valid, a_code_valid;
  logic [7:0]  a_in_data;
  logic [47:0] a_cnt, a_hc, a_hm;

  logic        b_in_valid, b_in_ready, b_in_last, b_cnt_valid, b_code_valid;
  logic [7:0]  b_in_data;
  logic [31:0] b_cnt;
  logic [11:0] b_hc, b_hm;

  huffman_gen #(.NSYM(6), .DW(8), .CW(8), .LW(8)) dut_a (
    .clk(clk), .reset_n(reset_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_last(a_in_last),
    .cnt_valid(a_cnt_valid), .cnt(a_cnt), .code_valid(a_code_valid), .hc(a_hc), .hm(a_hm)
  );

  huffman_gen #(.NSYM(4), .DW(8), .CW(8), .LW(3)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_last(b_in_last),
    .cnt_valid(b_cnt_valid), .cnt(b_cnt), .code_valid(b_code_valid), .hc(b_hc), .hm(b_hm)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic beat_a(input int sym, input bit last);
    a_in_valid = 1'b1;
    a_in_data  = 8'(sym);
    a_in_last  = last;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    a_in_last  = 1'b0;
  endtask

  task automatic syms_a(input int sym, input int n, input bit last_at_end);
    for (int k = 0; k < n; k++) beat_a(sym, last_at_end && (k == n - 1));
  endtask

  task automatic beat_b(input int sym, input bit last);
    b_in_valid = 1'b1;
    b_in_data  = 8'(sym);
    b_in_last  = last;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    b_in_last  = 1'b0;
  endtask

  task automatic wait_code_a(output int n);
    n = 0;
    while (a_code_valid !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic wait_code_b(output int n);
    n = 0;
    while (b_code_valid !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    logic early;
    reset_n    = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_in_last = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_in_last = 1'b0;
    #12;
    check("rst_in_ready",   64'(a_in_ready),   64'd1);
    check("rst_cnt",        64'(a_cnt),        64'd0);
    check("rst_cnt_valid",  64'(a_cnt_valid),  64'd0);
    check("rst_code_valid", 64'(a_code_valid), 64'd0);
    check("rst_hc",         64'(a_hc),         64'd0);
    check("rst_hm",         64'(a_hm),         64'd0);
    check("rst_b_in_ready", 64'(b_in_ready),   64'd1);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Distinct weights 12,2,5,3,8,40 with one ignored index-0 beat.
    syms_a(1, 12, 1'b0);
    syms_a(2, 2, 1'b0);
    beat_a(0, 1'b0);
    syms_a(3, 5, 1'b0);
    syms_a(4, 3, 1'b0);
    syms_a(5, 8, 1'b0);
    syms_a(6, 40, 1'b1);
    check("f1_cnt_valid",  64'(a_cnt_valid),  64'd1);
    check("f1_cnt",        64'(a_cnt),        64'h0000_2808_0305_020C);
    check("f1_code_low",   64'(a_code_valid), 64'd0);
    check("f1_ready_low",  64'(a_in_ready),   64'd0);

    // Next frame (single last beat of symbol 2) is held off by back-pressure.
    a_in_valid = 1'b1; a_in_data = 8'd2; a_in_last = 1'b1;
    n = 0; early = 1'b0;
    while (a_in_ready !== 1'b1 && n < 100) begin
      if (a_code_valid === 1'b1) early = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    check("f1_busy_cycles", 64'(n),            64'd35);
    check("f1_code_early",  64'(early),        64'd0);
    check("f1_code_valid",  64'(a_code_valid), 64'd1);
    check("f1_cnt_held",    64'(a_cnt),        64'h0000_2808_0305_020C);
    check("f1_hc",          64'(a_hc),         64'h0000_0005_1208_1303);
    check("f1_hm",          64'(a_hm),         64'h0000_0107_1F0F_1F03);
    @(posedge clk); #1;
    a_in_valid = 1'b0; a_in_last = 1'b0;
    check("f2_cnt_valid",  64'(a_cnt_valid),  64'd1);
    check("f2_cnt",        64'(a_cnt),        64'h0000_0000_0000_0100);
    check("f2_code_clr",   64'(a_code_valid), 64'd0);
    check("f2_hc_clr",     64'(a_hc),         64'd0);
    check("f2_hm_clr",     64'(a_hm),         64'd0);
    wait_code_a(n);
    check("f2_latency",    64'(n),            64'd35);
    check("f2_hc",         64'(a_hc),         64'h0000_1F1E_0E06_0002);
    check("f2_hm",         64'(a_hm),         64'h0000_1F1F_0F07_0103);

    // Equal weights, started from DONE.
    for (int s = 1; s <= 6; s++) beat_a(s, s == 6);
    check("f3_cnt",        64'(a_cnt),        64'h0000_0101_0101_0101);
    check("f3_code_clr",   64'(a_code_valid), 64'd0);
    @(posedge clk); #1;
    check("f3_pulse_end",  64'(a_cnt_valid),  64'd0);
    wait_code_a(n);
    check("f3_latency",    64'(n),            64'd34);
    check("f3_hc",         64'(a_hc),         64'h0000_0302_0100_0302);
    check("f3_hm",         64'(a_hm),         64'h0000_0303_0707_0707);

    // Out-of-range filtering and saturation.
    for (int k = 0; k < 300; k++) begin
      beat_a((k % 2 == 0) ? 7 : 0, 1'b0);
      beat_a(3, k == 299);
    end
    check("f4_cnt_sat",    64'(a_cnt),        64'h0000_0000_00FF_0000);
    wait_code_a(n);
    check("f4_code_valid", 64'(a_code_valid), 64'd1);

    // Reset in the middle of a build, then the same frame again.
    syms_a(1, 1, 1'b0);
    syms_a(2, 1, 1'b0);
    syms_a(3, 2, 1'b0);
    syms_a(4, 4, 1'b1);
    repeat (9) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("mid_rst_ready", 64'(a_in_ready),   64'd1);
    check("mid_rst_cnt",   64'(a_cnt),        64'd0);
    check("mid_rst_cv",    64'(a_cnt_valid),  64'd0);
    check("mid_rst_code",  64'(a_code_valid), 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    syms_a(1, 1, 1'b0);
    syms_a(2, 1, 1'b0);
    syms_a(3, 2, 1'b0);
    syms_a(4, 4, 1'b1);
    wait_code_a(n);
    check("f5_latency",    64'(n),            64'd35);
    check("f5_cnt",        64'(a_cnt),        64'h0000_0000_0402_0101);
    check("f5_hc",         64'(a_hc),         64'h0000_1F1E_0002_0E06);
    check("f5_hm",         64'(a_hm),         64'h0000_1F1F_0103_0F07);

    // Four-symbol instance, counts 1,1,2,4.
    beat_b(4, 1'b0); beat_b(1, 1'b0); beat_b(4, 1'b0); beat_b(3, 1'b0);
    beat_b(2, 1'b0); beat_b(4, 1'b0); beat_b(3, 1'b0); beat_b(4, 1'b1);
    check("b_cnt_valid",   64'(b_cnt_valid),  64'd1);
    check("b_cnt",         64'(b_cnt),        64'h0000_0000_0402_0101);
    wait_code_b(n);
    check("b_latency",     64'(n),            64'd15);
    check("b_hc",          64'(b_hc),         64'h0BE);
    check("b_hm",          64'(b_hm),         64'h2FF);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
